srlatch_exerciser: RTL and testbench



---
 rtl/srlatch_exerciser.sv | 153 +++++++++++++++
 tb/tb_srlatch_exerciser.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/srlatch_exerciser.sv
// Stimulus generator and checker for a gated SR latch.
// Optional macro SRX_COMPLEMENT_CHECK_EN also checks Qc against ~exp_q.
module srlatch_exerciser #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Q,
  input  logic       Qc,
  output logic       S,
  output logic       R,
  output logic       En,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [3:0] vec_idx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t     state, state_n;
  logic [3:0] idx_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] err_n;
  logic       exp_q, exp_q_n;
  logic       exp_known, known_n;
  logic [2:0] vec;
  logic       miss;

  function automatic logic [2:0] rom(input logic [3:0] i);
    unique case (i)
      4'd0:    rom = 3'b100;
      4'd1:    rom = 3'b010;
      4'd2:    rom = 3'b000;
      4'd3:    rom = 3'b110;
      4'd4:    rom = 3'b101;
      4'd5:    rom = 3'b111;
      4'd6:    rom = 3'b011;
      4'd7:    rom = 3'b111;
      4'd8:    rom = 3'b001;
      default: rom = 3'b000;
    endcase
  endfunction

  assign vec = rom(vec_idx);

  // Compare the latch against the model; unknown model means no check
  always_comb begin
`ifdef SRX_COMPLEMENT_CHECK_EN
    miss = exp_known && ((Q != exp_q) || (Qc == exp_q));
`else
    miss = exp_known && (Q != exp_q);
`endif
  end

  // Drive the current vector while a run is in progress, else 000
  always_comb begin
    {S, R, En} = 3'b000;
    busy = 1'b0;
    if (state == ST_APPLY || state == ST_SETTLE || state == ST_CHECK) begin
      {S, R, En} = vec;
      busy = 1'b1;
    end
  end

  assign done = (state == ST_DONE);
  assign pass = done && (err_count == 4'd0);

  // Next-state, counters and behavioural latch model
  always_comb begin
    state_n = state;
    idx_n   = vec_idx;
    cnt_n   = cnt;
    err_n   = err_count;
    exp_q_n = exp_q;
    known_n = exp_known;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_APPLY;
          idx_n   = 4'd0;
          err_n   = 4'd0;
          exp_q_n = 1'b0;
          known_n = 1'b0;
        end
      end
      ST_APPLY: begin
        cnt_n   = 4'(SETTLE);
        state_n = ST_SETTLE;
        if (vec[0]) begin
          unique case (vec[2:1])
            2'b10: begin
              exp_q_n = 1'b1;
              known_n = 1'b1;
            end
            2'b01: begin
              exp_q_n = 1'b0;
              known_n = 1'b1;
            end
            2'b11:   known_n = 1'b0;
            default: ;
          endcase
        end
      end
      ST_SETTLE: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_n   = 4'd0;
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (miss && err_count != 4'd15)
          err_n = err_count + 4'd1;
        if (vec_idx == 4'd8) begin
          state_n = ST_DONE;
        end else begin
          idx_n   = vec_idx + 4'd1;
          state_n = ST_APPLY;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      vec_idx   <= 4'd0;
      cnt       <= 4'd0;
      err_count <= 4'd0;
      exp_q     <= 1'b0;
      exp_known <= 1'b0;
    end else begin
      state     <= state_n;
      vec_idx   <= idx_n;
      cnt       <= cnt_n;
      err_count <= err_n;
      exp_q     <= exp_q_n;
      exp_known <= known_n;
    end
  end

endmodule

// File: tb/tb_srlatch_exerciser.sv
// Self-checking bench for srlatch_exerciser with a faultable latch model.
// Build with SRX_COMPLEMENT_CHECK_EN to exercise the Qc check.
module tb_srlatch_exerciser;

  localparam int P = 2;
  localparam int RUN = 9 * (P + 2);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       Q, Qc;
  logic       S, R, En;
  logic       busy, done, pass;
  logic [3:0] err_count, vec_idx;

  int checks = 0;
  int failures = 0;

  // 0 good, 1 Q stuck 0, 2 Q stuck 1, 3 Q inverted
  int q_mode = 0;
  // 0 good, 1 Qc stuck 1
  int qc_mode = 0;
  logic lq = 1'b0;

  logic [2:0] rom [9] = '{3'b100, 3'b010, 3'b000, 3'b110, 3'b101,
                          3'b111, 3'b011, 3'b111, 3'b001};

  srlatch_exerciser #(.SETTLE(P)) dut (
    .clk(clk), .rst(rst), .start(start), .Q(Q), .Qc(Qc),
    .S(S), .R(R), .En(En), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_idx(vec_idx)
  );

  always #5 clk = ~clk;

  // Gated SR latch stand-in
  always @(posedge clk) begin
    if (En && S && !R) lq <= 1'b1;
    else if (En && !S && R) lq <= 1'b0;
  end

  assign Q  = (q_mode == 1) ? 1'b0 : (q_mode == 2) ? 1'b1 :
              (q_mode == 3) ? ~lq : lq;
  assign Qc = (qc_mode == 1) ? 1'b1 : ~lq;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int qobs(input int qm, input logic l);
    case (qm)
      1:       return 0;
      2:       return 1;
      3:       return l ? 0 : 1;
      default: return l ? 1 : 0;
    endcase
  endfunction

  // Spec-level prediction of mismatches for one run
  function automatic int ref_err(input int qm, input int qcm);
    int n = 0;
    bit known = 0;
    bit expq = 0;
    bit bad;
    for (int v = 0; v < 9; v++) begin
      if (rom[v][0] && rom[v][2] != rom[v][1]) begin
        known = 1;
        expq = rom[v][2];
      end else if (rom[v] == 3'b111) begin
        known = 0;
      end
      if (known) begin
        bad = (qobs(qm, expq) != int'(expq));
`ifdef SRX_COMPLEMENT_CHECK_EN
        if (qcm == 1 && expq == 1'b1) bad = 1;
`endif
        if (bad && n < 15) n++;
      end
    end
    return n;
  endfunction

  task automatic run(input int qm, input int qcm, input int junk,
                     input int exp_err);
    int e;
    bit seq_ok;
    q_mode = qm;
    qc_mode = qcm;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_clears_done", int'(done), 0);
    chk("start_clears_err", int'(err_count), 0);
    e = 0;
    seq_ok = 1;
    while (!done && e < 200) begin
      if (!busy || int'(vec_idx) != e / (P + 2) ||
          {S, R, En} != rom[e / (P + 2)])
        seq_ok = 0;
      if (e == junk) start = 1'b1;
      step();
      start = 1'b0;
      e++;
    end
    chk("vector_sequence", int'(seq_ok), 1);
    chk("done_edge", e, RUN);
    chk("err_count", int'(err_count), exp_err);
    chk("pass", int'(pass), (exp_err == 0) ? 1 : 0);
    chk("done_sre", int'({S, R, En}), 0);
    chk("done_busy", int'(busy), 0);
  endtask

  typedef struct {
    int qm;
    int qcm;
    int junk;
    int err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{0, 0, -1, 0};
    tbl[1] = '{1, 0, -1, 1};
    tbl[2] = '{2, 0, -1, 1};
`ifdef SRX_COMPLEMENT_CHECK_EN
    tbl[3] = '{0, 1, -1, 1};
`else
    tbl[3] = '{0, 1, -1, 0};
`endif
    tbl[4] = '{3, 0, 12, 2};
    tbl[5] = '{0, 0, 12, 0};

    #12;
    chk("rst_sre", int'({S, R, En}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_idx", int'(vec_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("idle_no_start", int'(busy), 0);

    for (int i = 0; i < 6; i++)
      run(tbl[i].qm, tbl[i].qcm, tbl[i].junk, tbl[i].err);

    // Reset while settling vector 5
    q_mode = 0;
    qc_mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5 * (P + 2) + 1) step();
    chk("pre_rst_idx", int'(vec_idx), 5);
    rst = 1'b1;
    #1;
    chk("midrun_rst_sre", int'({S, R, En}), 0);
    chk("midrun_rst_busy", int'(busy), 0);
    chk("midrun_rst_idx", int'(vec_idx), 0);
    chk("midrun_rst_err", int'(err_count), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_idle", int'(busy | done), 0);
    run(0, 0, -1, 0);

    // Randomized fault modes, idle gaps and spurious starts
    for (int i = 0; i < 8; i++) begin
      int qm, qcm, junk;
      qm = $urandom_range(0, 3);
      qcm = $urandom_range(0, 1);
      junk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, RUN - 2) : -1;
      repeat ($urandom_range(0, 4)) step();
      run(qm, qcm, junk, ref_err(qm, qcm));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
